// File: rtl/spi_cmd_receiver.sv
// rtl/spi_cmd_receiver.sv - SPI slave command decoder feeding palette, misc and sprite shift controls
// Define SPI_READBACK_EN to build the MISO register readback path (op 5).
module spi_cmd_receiver #(
  parameter logic [5:0] COLOR1_DEFAULT = 6'b110001,
  parameter logic [5:0] COLOR2_DEFAULT = 6'b010101,
  parameter logic [5:0] COLOR3_DEFAULT = 6'b001100,
  parameter logic [5:0] COLOR4_DEFAULT = 6'b101100,
  parameter logic [4:0] MISC_DEFAULT   = 5'b00110
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       spi_cs,
  input  logic       sprite_data,
  output logic       spi_sprite_shift,
  output logic       spi_sprite_mode,
  output logic       spi_mosi_sync,
  output logic       shift_x,
  output logic       shift_y,
  output logic [5:0] color1,
  output logic [5:0] color2,
  output logic [5:0] color3,
  output logic [5:0] color4,
  output logic [4:0] misc
);

  typedef enum logic [2:0] {IDLE, CMD, WREG, SPRITE, POSX, POSY, RREG, IGNORE} state_t;

  state_t     state, state_nxt;
  logic [2:0] sclk_pipe, mosi_pipe, cs_pipe;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [3:0] cmd_addr;
  logic       sample, cs_fall, cs_rise, byte_done;
  logic [7:0] byte_in;
  logic       capture, sprite_nxt, x_nxt, y_nxt, wr_en;
  logic       unused_sprite_data;

  assign unused_sprite_data = sprite_data;

  // pipe[1] is the synchronised value, pipe[2] its one-cycle history.
  // cs resets low so a cs already asserted at reset release is not seen as a fresh falling edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_pipe <= 3'b000;
      mosi_pipe <= 3'b000;
      cs_pipe   <= 3'b000;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], spi_sclk};
      mosi_pipe <= {mosi_pipe[1:0], spi_mosi};
      cs_pipe   <= {cs_pipe[1:0], spi_cs};
    end
  end

  assign cs_fall   = cs_pipe[2] & ~cs_pipe[1];
  assign cs_rise   = ~cs_pipe[2] & cs_pipe[1];
  assign sample    = sclk_pipe[2] & ~sclk_pipe[1] & ~cs_rise;
  assign byte_done = sample & (bit_cnt == 3'd7);
  assign byte_in   = {rx_shift, mosi_pipe[1]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_nxt = CMD;
        CMD: begin
          if (byte_done) begin
            case (byte_in[7:4])
              4'd1:    state_nxt = WREG;
              4'd2:    state_nxt = SPRITE;
              4'd3:    state_nxt = POSX;
              4'd4:    state_nxt = POSY;
`ifdef SPI_READBACK_EN
              4'd5:    state_nxt = RREG;
`endif
              default: state_nxt = IGNORE;
            endcase
          end
        end
        WREG, POSX, POSY, RREG: if (byte_done) state_nxt = IGNORE;
        default: ;
      endcase
    end
  end

  always_comb begin
    capture         = 1'b0;
    sprite_nxt      = 1'b0;
    x_nxt           = 1'b0;
    y_nxt           = 1'b0;
    wr_en           = 1'b0;
    spi_sprite_mode = (state == SPRITE);
    if (sample) begin
      case (state)
        SPRITE: begin capture = 1'b1; sprite_nxt = 1'b1; end
        POSX:   begin capture = 1'b1; x_nxt = 1'b1; end
        POSY:   begin capture = 1'b1; y_nxt = 1'b1; end
        WREG:   wr_en = byte_done;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spi_sprite_shift <= 1'b0;
      shift_x          <= 1'b0;
      shift_y          <= 1'b0;
      spi_mosi_sync    <= 1'b0;
      bit_cnt          <= 3'd0;
      rx_shift         <= 7'd0;
      cmd_addr         <= 4'd0;
      color1           <= COLOR1_DEFAULT;
      color2           <= COLOR2_DEFAULT;
      color3           <= COLOR3_DEFAULT;
      color4           <= COLOR4_DEFAULT;
      misc             <= MISC_DEFAULT;
    end else begin
      spi_sprite_shift <= sprite_nxt;
      shift_x          <= x_nxt;
      shift_y          <= y_nxt;
      if (capture) spi_mosi_sync <= mosi_pipe[1];
      if (cs_fall)     bit_cnt <= 3'd0;
      else if (sample) bit_cnt <= bit_cnt + 3'd1;
      if (sample) rx_shift <= byte_in[6:0];
      if (state == CMD && byte_done) cmd_addr <= byte_in[3:0];
      if (wr_en) begin
        case (cmd_addr)
          4'd0:    color1 <= byte_in[5:0];
          4'd1:    color2 <= byte_in[5:0];
          4'd2:    color3 <= byte_in[5:0];
          4'd3:    color4 <= byte_in[5:0];
          4'd4:    misc   <= byte_in[4:0];
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] tx_shift;
  logic [7:0] read_val;
  logic       miso_q;
  logic       launch;

  assign launch = ~sclk_pipe[2] & sclk_pipe[1] & ~cs_rise;

  always_comb begin
    case (byte_in[3:0])
      4'd0:    read_val = {2'b00, color1};
      4'd1:    read_val = {2'b00, color2};
      4'd2:    read_val = {2'b00, color3};
      4'd3:    read_val = {2'b00, color4};
      4'd4:    read_val = {3'b000, misc};
      default: read_val = 8'h00;
    endcase
  end

  // Each launch edge presents the next bit; the host samples it on the following falling edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_shift <= 8'h00;
      miso_q   <= 1'b0;
    end else if (cs_rise) begin
      miso_q <= 1'b0;
    end else if (state == CMD && byte_done && byte_in[7:4] == 4'd5) begin
      tx_shift <= read_val;
    end else if (state == RREG) begin
      if (byte_done) begin
        miso_q <= 1'b0;
      end else if (launch) begin
        miso_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_miso = miso_q;
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb/tb_spi_cmd_receiver.sv - scoreboard bench for spi_cmd_receiver
module tb_spi_cmd_receiver;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_cs = 1'b1;
  logic sprite_data = 1'b0;
  logic spi_miso, spi_sprite_shift, spi_sprite_mode, spi_mosi_sync, shift_x, shift_y;
  logic [5:0] color1, color2, color3, color4;
  logic [4:0] misc;

  int n_checks = 0;
  int n_fail = 0;
  int rule_viol = 0;
  int miso_high = 0;
  bit prev_s = 0, prev_x = 0, prev_y = 0;
  bit sprite_exp[$], sprite_obs[$], x_exp[$], x_obs[$], y_exp[$], y_obs[$];
  logic [5:0] exp_color [4];
  logic [4:0] exp_misc;
  logic [5:0] col_obs [4];

  assign col_obs[0] = color1;
  assign col_obs[1] = color2;
  assign col_obs[2] = color3;
  assign col_obs[3] = color4;

  always #5 clk = ~clk;

  spi_cmd_receiver dut (
    .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs(spi_cs), .sprite_data(sprite_data),
    .spi_sprite_shift(spi_sprite_shift), .spi_sprite_mode(spi_sprite_mode),
    .spi_mosi_sync(spi_mosi_sync), .shift_x(shift_x), .shift_y(shift_y),
    .color1(color1), .color2(color2), .color3(color3), .color4(color4), .misc(misc)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (spi_sprite_shift) sprite_obs.push_back(spi_mosi_sync);
      if (shift_x) x_obs.push_back(spi_mosi_sync);
      if (shift_y) y_obs.push_back(spi_mosi_sync);
      if (int'(spi_sprite_shift) + int'(shift_x) + int'(shift_y) > 1) rule_viol++;
      if ((spi_sprite_shift && prev_s) || (shift_x && prev_x) || (shift_y && prev_y)) rule_viol++;
      if (spi_miso) miso_high++;
    end
    prev_s = spi_sprite_shift;
    prev_x = shift_x;
    prev_y = shift_y;
  end

  task automatic spi_bit(input bit b, output bit miso_s);
    spi_sclk = 1'b1;
    spi_mosi = b;
    repeat (HALF) @(posedge clk);
    #1 miso_s = spi_miso;
    spi_sclk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rd);
    bit m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      rd[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic cs_high(input int gap);
    spi_cs = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    sprite_exp.delete(); sprite_obs.delete();
    x_exp.delete(); x_obs.delete();
    y_exp.delete(); y_obs.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    spi_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (col_obs[i] !== exp_color[i]) begin
        n_fail++;
        $display("FAIL reset color%0d: got %h expected %h", i + 1, col_obs[i], exp_color[i]);
      end
    end
    n_checks++;
    if (misc !== 5'h06) begin n_fail++; $display("FAIL reset misc: got %h expected 06", misc); end
    n_checks++;
    if ({spi_sprite_shift, shift_x, shift_y, spi_sprite_mode, spi_mosi_sync, spi_miso} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b expected 000000",
               {spi_sprite_shift, shift_x, shift_y, spi_sprite_mode, spi_mosi_sync, spi_miso});
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_cs_low_at_reset();
    logic [7:0] rd;
    reset_n = 1'b0;
    spi_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    spi_byte(8'h14, rd);
    spi_byte(8'h1B, rd);
    cs_high(12);
    n_checks++;
    if (misc !== exp_misc) begin
      n_fail++;
      $display("FAIL cs_low_reset misc: got %h expected %h", misc, exp_misc);
    end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    cs_low(); spi_byte(8'h12, rd); spi_byte(8'h3F, rd); cs_high(12);
    exp_color[2] = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (col_obs[i] !== exp_color[i]) begin
        n_fail++;
        $display("FAIL write color%0d: got %h expected %h", i + 1, col_obs[i], exp_color[i]);
      end
    end
    n_checks++;
    if (misc !== exp_misc) begin n_fail++; $display("FAIL write misc: got %h expected %h", misc, exp_misc); end
    cs_low(); spi_byte(8'h17, rd); spi_byte(8'h2A, rd); spi_byte(8'h15, rd); cs_high(12);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (col_obs[i] !== exp_color[i]) begin
        n_fail++;
        $display("FAIL write_addr7 color%0d: got %h expected %h", i + 1, col_obs[i], exp_color[i]);
      end
    end
    n_checks++;
    if (misc !== exp_misc) begin n_fail++; $display("FAIL write_addr7 misc: got %h expected %h", misc, exp_misc); end
  endtask

  task automatic test_sprite();
    logic [7:0] rd;
    bit b, m, e, o;
    clear_queues();
    cs_low(); spi_byte(8'h20, rd);
    for (int i = 0; i < 144; i++) begin
      b = 1'($urandom_range(0, 1));
      sprite_exp.push_back(b);
      spi_bit(b, m);
    end
    n_checks++;
    if (spi_sprite_mode !== 1'b1) begin n_fail++; $display("FAIL sprite_mode_active: got %b expected 1", spi_sprite_mode); end
    spi_cs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (spi_sprite_mode !== 1'b0) begin n_fail++; $display("FAIL sprite_mode_drop: got %b expected 0", spi_sprite_mode); end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (sprite_obs.size() != 144) begin
      n_fail++;
      $display("FAIL sprite_count: got %0d expected 144", sprite_obs.size());
    end
    while (sprite_exp.size() > 0 && sprite_obs.size() > 0) begin
      e = sprite_exp.pop_front();
      o = sprite_obs.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sprite_bit: got %b expected %b", o, e); end
    end
    n_checks++;
    if (x_obs.size() + y_obs.size() != 0) begin
      n_fail++;
      $display("FAIL sprite_stray_xy: got %0d expected 0", x_obs.size() + y_obs.size());
    end
  endtask

  task automatic test_position(input logic [7:0] op, input logic [7:0] val);
    logic [7:0] rd;
    bit e, o;
    clear_queues();
    for (int i = 7; i >= 0; i--) begin
      if (op == 8'h30) x_exp.push_back(val[i]);
      else             y_exp.push_back(val[i]);
    end
    cs_low(); spi_byte(op, rd); spi_byte(val, rd); spi_byte(8'hFF, rd); cs_high(12);
    n_checks++;
    if (x_obs.size() != x_exp.size() || y_obs.size() != y_exp.size()) begin
      n_fail++;
      $display("FAIL pos_count op %h: got x=%0d y=%0d expected x=%0d y=%0d",
               op, x_obs.size(), y_obs.size(), x_exp.size(), y_exp.size());
    end
    while (x_exp.size() > 0 && x_obs.size() > 0) begin
      e = x_exp.pop_front(); o = x_obs.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL pos_x_bit: got %b expected %b", o, e); end
    end
    while (y_exp.size() > 0 && y_obs.size() > 0) begin
      e = y_exp.pop_front(); o = y_obs.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL pos_y_bit: got %b expected %b", o, e); end
    end
    n_checks++;
    if (sprite_obs.size() != 0) begin n_fail++; $display("FAIL pos_stray_sprite: got %0d expected 0", sprite_obs.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    bit m;
    cs_low(); spi_byte(8'h14, rd);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_high(12);
    n_checks++;
    if (misc !== exp_misc) begin n_fail++; $display("FAIL abort misc: got %h expected %h", misc, exp_misc); end
    cs_low(); spi_byte(8'h14, rd); spi_byte(8'h01, rd); cs_high(12);
    exp_misc = 5'h01;
    n_checks++;
    if (misc !== exp_misc) begin n_fail++; $display("FAIL abort_retry misc: got %h expected %h", misc, exp_misc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    clear_queues();
    cs_low(); spi_byte(8'h10, rd); spi_byte(8'h0A, rd); cs_high(4);
    cs_low(); spi_byte(8'h13, rd); spi_byte(8'hFE, rd); cs_high(4);
    cs_low(); spi_byte(8'h60, rd); spi_byte(8'hFF, rd); cs_high(12);
    exp_color[0] = 6'h0A;
    exp_color[3] = 6'h3E;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (col_obs[i] !== exp_color[i]) begin
        n_fail++;
        $display("FAIL b2b color%0d: got %h expected %h", i + 1, col_obs[i], exp_color[i]);
      end
    end
    n_checks++;
    if (sprite_obs.size() + x_obs.size() + y_obs.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_stray_pulses: got %0d expected 0", sprite_obs.size() + x_obs.size() + y_obs.size());
    end
  endtask

  task automatic test_readback();
    logic [7:0] rd;
    logic [7:0] exp_rd [3];
    logic [7:0] cmds [3];
    cmds[0] = 8'h50; exp_rd[0] = {2'b00, exp_color[0]};
    cmds[1] = 8'h54; exp_rd[1] = {3'b000, exp_misc};
    cmds[2] = 8'h59; exp_rd[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cs_low(); spi_byte(cmds[k], rd); spi_byte(8'h00, rd);
      repeat (4) @(posedge clk);
      #1;
`ifdef SPI_READBACK_EN
      n_checks++;
      if (rd !== exp_rd[k]) begin n_fail++; $display("FAIL readback cmd %h: got %h expected %h", cmds[k], rd, exp_rd[k]); end
`else
      n_checks++;
      if (rd !== 8'h00) begin n_fail++; $display("FAIL readback_off cmd %h: got %h expected 00", cmds[k], rd); end
`endif
      n_checks++;
      if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL readback_idle_miso: got %b expected 0", spi_miso); end
      cs_high(12);
    end
`ifndef SPI_READBACK_EN
    n_checks++;
    if (miso_high != 0) begin n_fail++; $display("FAIL miso_tied: got %0d high cycles expected 0", miso_high); end
`endif
  endtask

  task automatic test_pulse_rules();
    n_checks++;
    if (rule_viol != 0) begin n_fail++; $display("FAIL pulse_rules: got %0d violations expected 0", rule_viol); end
  endtask

  initial begin
    exp_color[0] = 6'h31;
    exp_color[1] = 6'h15;
    exp_color[2] = 6'h0C;
    exp_color[3] = 6'h2C;
    exp_misc = 5'h06;
    test_reset();
    test_cs_low_at_reset();
    cs_high(12);
    test_write();
    test_sprite();
    test_position(8'h30, 8'hA5);
    test_position(8'h40, 8'h3C);
    test_readback();
    test_abort();
    test_back_to_back();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
